des_round_state: RTL and testbench

- Feistel round-state engine for the iterative DES datapath; directly downstream of straight_pbox.
- Holds the L/R half-block registers and drives the current R half to the f-function path (expansion, key XOR, S-boxes, straight_pbox).
- Consumes the straight_pbox output and applies L' = R, R' = L ^ f for the configured number of rounds.
- Emits the pre-output block R16‖L16 to the final permutation.

---
 rtl/des_round_state.sv | 104 ++++++++++
 tb/tb_des_round_state.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_state.sv
// Feistel round-state engine: holds L/R halves, feeds R to the f-function
// and folds the straight_pbox result back until the pre-output is ready.
//
// Parameters:
//   ROUNDS     Feistel rounds per block, 1..16
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   START      start request, sampled only in IDLE
//   BLOCK_IN   post-IP block, [0:31]=L0, [32:63]=R0
//   F_IN       f-function result for the current round
//   F_VALID    F_IN valid, consumed in the same cycle
//   ABORT      (DES_ROUND_ABORT_EN only) cancel the block in flight
//   R_OUT      current R half, to the expansion box
//   ROUND      current round index, to the subkey select
//   BUSY       high while waiting for f results
//   DONE       one-cycle pulse when BLOCK_OUT is updated
//   BLOCK_OUT  pre-output {R16, L16}, held until the next DONE
//
// Build option: define DES_ROUND_ABORT_EN to add the ABORT input.

module des_round_state #(
    parameter int ROUNDS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [0:63] BLOCK_IN,
    input  logic [0:31] F_IN,
    input  logic        F_VALID,
`ifdef DES_ROUND_ABORT_EN
    input  logic        ABORT,
`endif
    output logic [0:31] R_OUT,
    output logic [3:0]  ROUND,
    output logic        BUSY,
    output logic        DONE,
    output logic [0:63] BLOCK_OUT
);

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_F = 1'b1
    } state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t      state;
    logic [0:31] l_q;
    logic [0:31] r_q;
    logic        abort;

`ifdef DES_ROUND_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    assign R_OUT = r_q;
    assign BUSY  = (state == WAIT_F);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            l_q       <= '0;
            r_q       <= '0;
            ROUND     <= '0;
            BLOCK_OUT <= '0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        l_q   <= BLOCK_IN[0:31];
                        r_q   <= BLOCK_IN[32:63];
                        ROUND <= '0;
                        state <= WAIT_F;
                    end
                end
                WAIT_F: begin
                    if (abort) begin
                        ROUND <= '0;
                        state <= IDLE;
                    end else if (F_VALID) begin
                        if (ROUND == LAST) begin
                            // last round leaves the halves unswapped
                            BLOCK_OUT <= {l_q ^ F_IN, r_q};
                            DONE      <= 1'b1;
                            ROUND     <= '0;
                            state     <= IDLE;
                        end else begin
                            l_q   <= r_q;
                            r_q   <= l_q ^ F_IN;
                            ROUND <= ROUND + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_state.sv
// Directed bench for des_round_state: ROUNDS=16 and ROUNDS=1 instances,
// stalls, ignored START, back-to-back blocks, mid-block reset, abort.

module tb_des_round_state;

    logic        CLK = 1'b0;
    logic        RST_A, RST_B;
    logic        START_A, START_B;
    logic [0:63] BLOCK_IN;
    logic [0:31] F_IN;
    logic        F_VALID;
    logic        ABORT_A, ABORT_B;

    logic [0:31] R_OUT_A, R_OUT_B;
    logic [3:0]  ROUND_A, ROUND_B;
    logic        BUSY_A, BUSY_B;
    logic        DONE_A, DONE_B;
    logic [0:63] BLOCK_OUT_A, BLOCK_OUT_B;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    des_round_state #(.ROUNDS(16)) dut_a (
        .CLK       (CLK),
        .RST       (RST_A),
        .START     (START_A),
        .BLOCK_IN  (BLOCK_IN),
        .F_IN      (F_IN),
        .F_VALID   (F_VALID),
`ifdef DES_ROUND_ABORT_EN
        .ABORT     (ABORT_A),
`endif
        .R_OUT     (R_OUT_A),
        .ROUND     (ROUND_A),
        .BUSY      (BUSY_A),
        .DONE      (DONE_A),
        .BLOCK_OUT (BLOCK_OUT_A)
    );

    des_round_state #(.ROUNDS(1)) dut_b (
        .CLK       (CLK),
        .RST       (RST_B),
        .START     (START_B),
        .BLOCK_IN  (BLOCK_IN),
        .F_IN      (F_IN),
        .F_VALID   (F_VALID),
`ifdef DES_ROUND_ABORT_EN
        .ABORT     (ABORT_B),
`endif
        .R_OUT     (R_OUT_B),
        .ROUND     (ROUND_B),
        .BUSY      (BUSY_B),
        .DONE      (DONE_B),
        .BLOCK_OUT (BLOCK_OUT_B)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one block on dut_a with F_VALID every p-th cycle.
    // poke: round at which a stray START is pulsed (-1 none).
    // chain: start next_blk in the DONE cycle.
    // skip: the START for this block was already raised by the caller.
    task automatic run_a(input string tag,
                         input logic [63:0] blk,
                         input logic [31:0] f,
                         input int p,
                         input int poke,
                         input logic [63:0] exp_out,
                         input bit skip,
                         input bit chain,
                         input logic [63:0] next_blk);
        logic [31:0] ml, mr, t;
        int rnd, cyc;
        bit seen;
        ml = blk[63:32];
        mr = blk[31:0];
        rnd = 0;
        seen = 0;
        F_IN = f;
        F_VALID = 1'b0;
        if (!skip) begin
            BLOCK_IN = blk;
            START_A = 1'b1;
        end
        tick();
        START_A = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (DONE_A) begin
                seen = 1;
                break;
            end
            chk({tag, "_busy"}, 64'(BUSY_A), 64'd1);
            chk({tag, "_round"}, 64'(ROUND_A), 64'(rnd));
            chk({tag, "_rout"}, 64'(R_OUT_A), 64'(mr));
            F_VALID = ((cyc % p) == 0);
            START_A = (poke >= 0 && rnd == poke && F_VALID);
            tick();
            START_A = 1'b0;
            if (F_VALID) begin
                if (rnd < 15) begin
                    t = ml;
                    ml = mr;
                    mr = t ^ f;
                    rnd++;
                end else begin
                    rnd = 0;
                end
            end
            cyc++;
        end
        F_VALID = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(1 + 16 * p));
        chk({tag, "_out"}, 64'(BLOCK_OUT_A), exp_out);
        chk({tag, "_busy_at_done"}, 64'(BUSY_A), 64'd0);
        chk({tag, "_round_at_done"}, 64'(ROUND_A), 64'd0);
        if (chain) begin
            BLOCK_IN = next_blk;
            START_A = 1'b1;
        end else begin
            tick();
            chk({tag, "_done_pulse"}, 64'(DONE_A), 64'd0);
            chk({tag, "_out_hold"}, 64'(BLOCK_OUT_A), exp_out);
        end
    endtask

    initial begin
        RST_A = 1'b1;
        RST_B = 1'b1;
        START_A = 1'b0;
        START_B = 1'b0;
        BLOCK_IN = '0;
        F_IN = '0;
        F_VALID = 1'b0;
        ABORT_A = 1'b0;
        ABORT_B = 1'b0;
        tick();
        tick();
        RST_A = 1'b0;
        RST_B = 1'b0;
        chk("rst_busy", 64'(BUSY_A), 64'd0);
        chk("rst_done", 64'(DONE_A), 64'd0);
        chk("rst_round", 64'(ROUND_A), 64'd0);
        chk("rst_out", 64'(BLOCK_OUT_A), 64'd0);
        chk("rst_rout", 64'(R_OUT_A), 64'd0);
        chk("rst_b_out", 64'(BLOCK_OUT_B), 64'd0);

        run_a("r16", 64'h0123456789ABCDEF, 32'h0, 1, -1,
              64'h89ABCDEF01234567, 0, 0, 64'h0);
        run_a("p3", 64'h0123456789ABCDEF, 32'hFFFFFFFF, 3, -1,
              64'h89ABCDEF01234567, 0, 0, 64'h0);
        run_a("poke", 64'h0123456789ABCDEF, 32'h0, 1, 5,
              64'h89ABCDEF01234567, 0, 1, 64'hFEDCBA9876543210);
        run_a("chain", 64'hFEDCBA9876543210, 32'h0, 1, -1,
              64'h76543210FEDCBA98, 1, 0, 64'h0);

        // reset in the middle of a block
        BLOCK_IN = 64'h0123456789ABCDEF;
        F_IN = 32'h0;
        START_A = 1'b1;
        tick();
        START_A = 1'b0;
        F_VALID = 1'b1;
        repeat (8) tick();
        chk("mid_round", 64'(ROUND_A), 64'd8);
        RST_A = 1'b1;
        tick();
        RST_A = 1'b0;
        F_VALID = 1'b0;
        chk("mid_rst_busy", 64'(BUSY_A), 64'd0);
        chk("mid_rst_round", 64'(ROUND_A), 64'd0);
        chk("mid_rst_out", 64'(BLOCK_OUT_A), 64'd0);
        chk("mid_rst_done", 64'(DONE_A), 64'd0);
        tick();
        chk("mid_rst_done2", 64'(DONE_A), 64'd0);
        run_a("clean", 64'h0123456789ABCDEF, 32'h12345678, 1, -1,
              64'h89ABCDEF01234567, 0, 0, 64'h0);

        // single-round instance
        BLOCK_IN = 64'h0;
        F_IN = 32'hFFFFFFFF;
        F_VALID = 1'b1;
        START_B = 1'b1;
        tick();
        START_B = 1'b0;
        chk("r1_busy", 64'(BUSY_B), 64'd1);
        chk("r1_round", 64'(ROUND_B), 64'd0);
        chk("r1_done_early", 64'(DONE_B), 64'd0);
        tick();
        F_VALID = 1'b0;
        chk("r1_done", 64'(DONE_B), 64'd1);
        chk("r1_busy_off", 64'(BUSY_B), 64'd0);
        chk("r1_out", 64'(BLOCK_OUT_B), 64'hFFFFFFFF00000000);
        tick();
        chk("r1_done_pulse", 64'(DONE_B), 64'd0);

`ifdef DES_ROUND_ABORT_EN
        BLOCK_IN = 64'hFEDCBA9876543210;
        F_IN = 32'h0;
        START_A = 1'b1;
        tick();
        START_A = 1'b0;
        F_VALID = 1'b1;
        repeat (4) tick();
        chk("ab_round", 64'(ROUND_A), 64'd4);
        ABORT_A = 1'b1;
        tick();
        ABORT_A = 1'b0;
        F_VALID = 1'b0;
        chk("ab_busy", 64'(BUSY_A), 64'd0);
        chk("ab_round0", 64'(ROUND_A), 64'd0);
        chk("ab_done", 64'(DONE_A), 64'd0);
        chk("ab_out", 64'(BLOCK_OUT_A), 64'h89ABCDEF01234567);
        tick();
        chk("ab_done2", 64'(DONE_A), 64'd0);
        run_a("after_ab", 64'hFEDCBA9876543210, 32'h0, 1, -1,
              64'h76543210FEDCBA98, 0, 0, 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
